// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side controller of an async FIFO: synchronises the write gray pointer, owns the
// read pointer, sequences the 1-cycle RAM read and presents an FWFT valid/ready output.
module fifo_rd_ptr_ctrl #(
  parameter int PTR         = 8,
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [PTR:0]   wr_ptr_gray_in,
  output logic [PTR:0]   rd_ptr_gray,
  output logic           ram_rd_en,
  output logic [PTR-1:0] ram_rd_addr,
  input  logic [DW-1:0]  ram_rd_data,
  output logic [DW-1:0]  dout,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic           empty,
  output logic [PTR:0]   rd_level
);

  // Handshake: a word moves from dout to the consumer on every clock edge where
  // dout_valid and dout_ready are both high; dout/dout_valid hold while stalled.

  logic [PTR:0]  sync_q [SYNC_STAGES];
  logic [PTR:0]  sync_d [SYNC_STAGES];
  logic [PTR:0]  wr_gray_sync;
  logic [PTR:0]  wr_bin_sync;

  logic [PTR:0]  rd_bin_q, rd_bin_d;
  logic [PTR:0]  rd_gray_q, rd_gray_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;

  logic [1:0]    occ;
  logic [1:0]    occ_after_pop;
  logic          pop;
  logic          issue;

  always_comb begin
    sync_d[0] = wr_ptr_gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign wr_gray_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    wr_bin_sync = '0;
    for (int i = 0; i <= PTR; i++) begin
      wr_bin_sync[i] = ^(wr_gray_sync >> i);
    end
  end

  assign empty    = (rd_gray_q == wr_gray_sync);
  assign rd_level = wr_bin_sync - rd_bin_q;

  // occ counts every word already committed to the output side, including one in flight.
  assign pop           = dout_valid_q & dout_ready;
  assign occ           = {1'b0, dout_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q};
  assign occ_after_pop = occ - {1'b0, pop};
  assign issue         = !empty && (occ_after_pop < 2'd2);

  always_comb begin
    rd_bin_d  = rd_bin_q;
    rd_gray_d = rd_gray_q;
    pend_d    = issue;
    if (issue) begin
      rd_bin_d  = rd_bin_q + {{PTR{1'b0}}, 1'b1};
      rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
    end
  end

  // Skid is only ever occupied while dout is, and never together with an in-flight read,
  // so landing data can simply fill whichever slot is free after the pop is applied.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (pop) begin
      if (skid_valid_q) begin
        dout_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        dout_valid_d = 1'b0;
      end
    end
    if (pend_q) begin
      if (!dout_valid_d) begin
        dout_d       = ram_rd_data;
        dout_valid_d = 1'b1;
      end else begin
        skid_d       = ram_rd_data;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      rd_bin_q     <= '0;
      rd_gray_q    <= '0;
      pend_q       <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      rd_bin_q     <= rd_bin_d;
      rd_gray_q    <= rd_gray_d;
      pend_q       <= pend_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign rd_ptr_gray = rd_gray_q;
  assign ram_rd_en   = issue;
  assign ram_rd_addr = rd_bin_q[PTR-1:0];
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;

endmodule
